// File: rtl/yuv_zigzag_serializer.sv
// Captures one Y/U/V MCU of 8x8 signed DCT coefficients and streams all 192
// values in JPEG zigzag order (Y, then U, then V) over a valid/ready interface.
module yuv_zigzag_serializer #(
    parameter int MCU_SIZE     = 8,
    parameter int OUT_BITWIDTH = 12
) (
    input  logic                                       clk,
    input  logic                                       n_rst,
    input  logic [MCU_SIZE*MCU_SIZE*OUT_BITWIDTH-1:0]  i_y,
    input  logic [MCU_SIZE*MCU_SIZE*OUT_BITWIDTH-1:0]  i_u,
    input  logic [MCU_SIZE*MCU_SIZE*OUT_BITWIDTH-1:0]  i_v,
    input  logic                                       i_valid,
    input  logic                                       i_last,
    output logic                                       o_wait,
    output logic [OUT_BITWIDTH-1:0]                    o_coef,
    output logic [1:0]                                 o_comp,
    output logic [5:0]                                 o_zz_idx,
    output logic                                       o_sob,
    output logic                                       o_eob,
    output logic                                       o_last,
    output logic                                       o_valid,
    input  logic                                       i_ready
);

    // Handshakes: upstream blocks are taken in IDLE whenever i_valid is high and
    // must be held while o_wait is high; an output beat transfers on a rising
    // clk edge where o_valid & i_ready, and all outputs hold while o_valid & !i_ready.

    generate
        if (MCU_SIZE != 8) begin : g_bad_mcu_size
            $error("yuv_zigzag_serializer: MCU_SIZE must be 8 (fixed 8x8 zigzag table)");
        end
    endgenerate

    localparam int NCOEF = 64;

    // Zigzag position -> natural raster index r*8+c.
    localparam logic [5:0] ZZ [0:NCOEF-1] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              comp_q, comp_d;
    logic [5:0]              k_q, k_d;
    logic                    last_q, last_d;
    logic                    capture;
    logic [5:0]              nat_idx;
    logic [OUT_BITWIDTH-1:0] coef_sel;

    logic [OUT_BITWIDTH-1:0] y_buf [0:NCOEF-1];
    logic [OUT_BITWIDTH-1:0] u_buf [0:NCOEF-1];
    logic [OUT_BITWIDTH-1:0] v_buf [0:NCOEF-1];

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            comp_q  <= 2'd0;
            k_q     <= 6'd0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            comp_q  <= comp_d;
            k_q     <= k_d;
            last_q  <= last_d;
        end
    end

    // Capture buffer is datapath only; the FSM decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (n_rst && capture) begin
            for (int n = 0; n < NCOEF; n++) begin
                y_buf[n] <= i_y[n*OUT_BITWIDTH +: OUT_BITWIDTH];
                u_buf[n] <= i_u[n*OUT_BITWIDTH +: OUT_BITWIDTH];
                v_buf[n] <= i_v[n*OUT_BITWIDTH +: OUT_BITWIDTH];
            end
        end
    end

    always_comb begin
        nat_idx  = ZZ[k_q];
        coef_sel = '0;
        case (comp_q)
            2'd0:    coef_sel = y_buf[nat_idx];
            2'd1:    coef_sel = u_buf[nat_idx];
            default: coef_sel = v_buf[nat_idx];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        comp_d   = comp_q;
        k_d      = k_q;
        last_d   = last_q;
        capture  = 1'b0;
        o_wait   = 1'b0;
        o_valid  = 1'b0;
        o_coef   = '0;
        o_comp   = 2'd0;
        o_zz_idx = 6'd0;
        o_sob    = 1'b0;
        o_eob    = 1'b0;
        o_last   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    capture = 1'b1;
                    last_d  = i_last;
                    comp_d  = 2'd0;
                    k_d     = 6'd0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                o_wait   = 1'b1;
                o_valid  = 1'b1;
                o_coef   = coef_sel;
                o_comp   = comp_q;
                o_zz_idx = k_q;
                o_sob    = (k_q == 6'd0);
                o_eob    = (k_q == 6'd63);
                o_last   = last_q && (comp_q == 2'd2) && (k_q == 6'd63);
                if (i_ready) begin
                    if (k_q == 6'd63) begin
                        k_d = 6'd0;
                        if (comp_q == 2'd2) begin
                            comp_d  = 2'd0;
                            state_d = S_IDLE;
                        end else begin
                            comp_d = comp_q + 2'd1;
                        end
                    end else begin
                        k_d = k_q + 6'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_yuv_zigzag_serializer.sv
// Directed bench for yuv_zigzag_serializer: drives hand-built MCUs and checks every
// output cycle against an expected-beat queue plus hand-computed spot values.
module tb_yuv_zigzag_serializer;

    localparam int W  = 12;
    localparam int N  = 64;
    localparam int BW = N * W;

    logic          clk = 1'b0;
    logic          n_rst;
    logic [BW-1:0] i_y, i_u, i_v;
    logic          i_valid, i_last, i_ready;
    logic          o_wait, o_sob, o_eob, o_last, o_valid;
    logic [W-1:0]  o_coef;
    logic [1:0]    o_comp;
    logic [5:0]    o_zz_idx;

    int n_tests = 0;
    int n_fail  = 0;

    logic [24:0]  exp_q[$];
    logic [W-1:0] got_coef [192];
    int           got_last_cnt;
    int           stream_cycles;
    int           wait_cycles;

    int zz_tab [64] = '{
        0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };
    int t1_first [6] = '{0, 1, 8, 16, 9, 2};

    yuv_zigzag_serializer #(.MCU_SIZE(8), .OUT_BITWIDTH(W)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .i_y      (i_y),
        .i_u      (i_u),
        .i_v      (i_v),
        .i_valid  (i_valid),
        .i_last   (i_last),
        .o_wait   (o_wait),
        .o_coef   (o_coef),
        .o_comp   (o_comp),
        .o_zz_idx (o_zz_idx),
        .o_sob    (o_sob),
        .o_eob    (o_eob),
        .o_last   (o_last),
        .o_valid  (o_valid),
        .i_ready  (i_ready)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // kind 0: ramp, kind 1: alternate data, kind 2: extreme corner values
    function automatic logic [W-1:0] block_val(input int kind, input int comp, input int n);
        int x;
        x = 0;
        case (kind)
            0: x = (comp == 0) ? n : (comp == 1) ? 100 + n : -n;
            1: x = (comp == 0) ? 200 + n : (comp == 1) ? -100 - n : 1000 + n;
            default: x = (comp == 0 && n == 0) ? -2048 : (comp == 0 && n == 63) ? 2047 : 0;
        endcase
        return x[W-1:0];
    endfunction

    function automatic logic [24:0] dut_out();
        return {o_wait, o_valid, o_comp, o_zz_idx, o_sob, o_eob, o_last, o_coef};
    endfunction

    // driver tasks
    task automatic fill(input int kind);
        for (int n = 0; n < N; n++) begin
            i_y[n*W +: W] = block_val(kind, 0, n);
            i_u[n*W +: W] = block_val(kind, 1, n);
            i_v[n*W +: W] = block_val(kind, 2, n);
        end
    endtask

    task automatic capture_mcu(input int kind, input bit last_mcu);
        fill(kind);
        i_valid = 1'b1;
        i_last  = last_mcu;
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic load_expected(input int kind, input bit last_mcu);
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < N; k++) begin
                exp_q.push_back({1'b1, 1'b1, 2'(c), 6'(k), (k == 0), (k == 63),
                                 (last_mcu && c == 2 && k == 63), block_val(kind, c, zz_tab[k])});
            end
        end
    endtask

    // mode 0: ready always high; mode 1: every beat stalls one cycle first
    task automatic run_stream(input int mode, input int nbeats);
        int b;
        bit phase;
        logic rdy;
        b = 0;
        phase = 1'b0;
        stream_cycles = 0;
        wait_cycles = 0;
        got_last_cnt = 0;
        while (b < nbeats && stream_cycles < 1000 && exp_q.size() > 0) begin
            rdy = (mode == 0) ? 1'b1 : phase;
            phase = ~phase;
            i_ready = rdy;
            check($sformatf("beat%0d", b), 32'(dut_out()), 32'(exp_q[0]));
            if (o_wait) wait_cycles++;
            if (rdy) begin
                got_coef[b] = o_coef;
                if (o_last) got_last_cnt++;
                void'(exp_q.pop_front());
                b++;
            end
            stream_cycles++;
            @(negedge clk);
        end
        check("stream_beats", b, nbeats);
    endtask

    initial begin
        n_rst   = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        i_y = '0;
        i_u = '0;
        i_v = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(dut_out()), 0);
        n_rst = 1'b1;
        @(negedge clk);
        check("idle_outputs", 32'(dut_out()), 0);

        // 1: single MCU, ready held high
        capture_mcu(0, 1'b0);
        load_expected(0, 1'b0);
        run_stream(0, 192);
        for (int i = 0; i < 6; i++) check($sformatf("t1_y%0d", i), got_coef[i], t1_first[i]);
        check("t1_y63", got_coef[63], 63);
        check("t1_u0", got_coef[64], 100);
        check("t1_u1", got_coef[65], 101);
        check("t1_u2", got_coef[66], 108);
        check("t1_u63", got_coef[127], 163);
        check("t1_v1", got_coef[129], 12'hFFF);
        check("t1_v2", got_coef[130], 12'hFF8);
        check("t1_v63", got_coef[191], 12'hFC1);
        check("t1_last_cnt", got_last_cnt, 0);
        check("t1_cycles", stream_cycles, 192);
        check("t1_wait_cycles", wait_cycles, 192);
        check("t1_idle_after", {o_wait, o_valid}, 0);

        // 2: same MCU with each beat stalled once
        capture_mcu(0, 1'b0);
        load_expected(0, 1'b0);
        run_stream(1, 192);
        check("t2_cycles", stream_cycles, 384);
        check("t2_v63", got_coef[191], 12'hFC1);
        check("t2_idle_after", {o_wait, o_valid}, 0);
        i_ready = 1'b1;

        // 3: two MCUs back-to-back, second flagged last
        capture_mcu(0, 1'b0);
        load_expected(0, 1'b0);
        run_stream(0, 192);
        check("t3_mcu1_last_cnt", got_last_cnt, 0);
        capture_mcu(0, 1'b1);
        load_expected(0, 1'b1);
        run_stream(0, 192);
        check("t3_mcu2_last_cnt", got_last_cnt, 1);
        check("t3_mcu2_v63", got_coef[191], 12'hFC1);
        check("t3_idle_after", {o_wait, o_valid, o_last}, 0);

        // 4: i_valid held with new data throughout the stream
        fill(0);
        i_valid = 1'b1;
        @(negedge clk);
        fill(1);
        load_expected(0, 1'b0);
        run_stream(0, 192);
        check("t4_idle_gap", {o_wait, o_valid}, 0);
        @(negedge clk);
        i_valid = 1'b0;
        check("t4_second_first_valid", o_valid, 1);
        load_expected(1, 1'b0);
        run_stream(0, 192);
        check("t4_second_y0", got_coef[0], 200);
        check("t4_second_u0", got_coef[64], 12'hF9C);
        check("t4_second_v63", got_coef[191], 1063);

        // 5: reset during beat 50 of Y
        capture_mcu(0, 1'b0);
        load_expected(0, 1'b0);
        run_stream(0, 50);
        check("t5_beat50_idx", o_zz_idx, 50);
        check("t5_beat50_coef", o_coef, zz_tab[50]);
        exp_q.delete();
        n_rst = 1'b0;
        @(negedge clk);
        check("t5_reset_outputs", 32'(dut_out()), 0);
        n_rst = 1'b1;
        capture_mcu(0, 1'b0);
        load_expected(0, 1'b0);
        run_stream(0, 192);
        check("t5_restart_y1", got_coef[1], 1);

        // 6: extreme values pass bit-exact
        capture_mcu(2, 1'b0);
        load_expected(2, 1'b0);
        run_stream(0, 192);
        check("t6_min", got_coef[0], 12'h800);
        check("t6_max", got_coef[63], 12'h7FF);
        check("t6_u0", got_coef[64], 0);

        // report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
